md_issue_ctrl: RTL and testbench

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_pkg.sv | 39 +++
 rtl/md_lat_cnt.sv | 33 +++
 rtl/md_issue_ctrl.sv | 73 +++++++
 tb/tb_md_issue_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared MD definitions: opcode encodings and default latencies, used by
// the issue controller and the MD datapath unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NE    = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110
  } md_op_e;

  localparam int MD_MUL_LAT = 4;
  localparam int MD_DIV_LAT = 8;
  localparam int MD_CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  // Opcodes that occupy the unit for several cycles
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  // Single-cycle HI/LO writes that bypass the FSM
  function automatic logic md_is_mt(input logic [2:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Latency down-counter: loads LAT-1 on issue, counts down while the
// operation is in flight, holds at zero; clear wins over load.
module md_lat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, load, or decrement toward zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (load_i)                  cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))   cnt_d = cnt_q - 1'b1;
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// MD issue controller: issues mult/div from EX, tracks busy time, stalls
// dependent MD instructions, and aborts/restores on exceptions in MEM.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT,
  parameter int DIV_LAT = MD_DIV_LAT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] md_op_ex,
  input  logic       mf_ex,
  input  logic       cancel_ex,
  input  logic       exc_mem,
  output logic       start,
  output logic [2:0] md_ctrl,
  output logic       busy,
  output logic       stall,
  output logic       abort,
  output logic       restore,
  output logic       done
);

  localparam logic [MD_CNT_W-1:0] MUL_LD = MD_CNT_W'(MUL_LAT - 1);
  localparam logic [MD_CNT_W-1:0] DIV_LD = MD_CNT_W'(DIV_LAT - 1);

  md_state_e state_q;
  logic      md_in_mem_q, mt_in_mem_q;
  logic      issue, mt_pass, cnt_zero;

  // Issue decode and outputs; everything is forced quiet while reset is high
  always_comb begin
    issue   = !reset && (state_q == S_IDLE) && !cancel_ex && md_is_long(md_op_ex);
    mt_pass = !reset && (state_q == S_IDLE) && !cancel_ex && md_is_mt(md_op_ex);
    busy    = !reset && (state_q != S_IDLE);
    abort   = !reset && exc_mem && md_in_mem_q;
    restore = !reset && exc_mem && mt_in_mem_q;
    // An aborted operation never reports completion, even on its last cycle
    done    = busy && cnt_zero && !abort;
    stall   = busy && !cancel_ex && ((md_op_ex != MD_NE) || mf_ex);
    start   = issue;
    md_ctrl = (issue || mt_pass) ? md_op_ex : MD_NE;
  end

  md_lat_cnt #(.W(MD_CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (issue),
    .load_val_i (md_is_mul(md_op_ex) ? MUL_LD : DIV_LD),
    .clr_i      (abort),
    .en_i       (busy),
    .zero_o     (cnt_zero)
  );

  // FSM plus one-cycle flags marking an MD/MT instruction sitting in MEM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      md_in_mem_q <= 1'b0;
      mt_in_mem_q <= 1'b0;
    end else begin
      md_in_mem_q <= issue;
      mt_in_mem_q <= mt_pass;
      case (state_q)
        S_IDLE: if (issue) state_q <= md_is_mul(md_op_ex) ? S_MUL : S_DIV;
        S_MUL,
        S_DIV:  if (abort || done) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Table-driven bench for md_issue_ctrl with default latencies (4/8).
// Each table row is one clock cycle of inputs plus the outputs expected
// during that cycle; expectations pass through a scoreboard queue.
module tb_md_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] md_op_ex;
  logic       mf_ex, cancel_ex, exc_mem;
  logic       start, busy, stall, abort, restore, done;
  logic [2:0] md_ctrl;

  md_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .md_op_ex  (md_op_ex),
    .mf_ex     (mf_ex),
    .cancel_ex (cancel_ex),
    .exc_mem   (exc_mem),
    .start     (start),
    .md_ctrl   (md_ctrl),
    .busy      (busy),
    .stall     (stall),
    .abort     (abort),
    .restore   (restore),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         r;
    logic [2:0] op;
    bit         mf, cx, ex;
    bit         st;
    logic [2:0] ctl;
    bit         bz, sl, ab, rs, dn;
    bit         cc;   // also require the latency counter to read zero
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] NE = 3'b000, MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011,
                         DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110;

  task automatic v(input string n, input bit r, input logic [2:0] op, input bit mf,
                   input bit cx, input bit ex, input bit st, input logic [2:0] ctl,
                   input bit bz, input bit sl, input bit ab, input bit rs, input bit dn,
                   input bit cc = 1'b0);
    vec_t t;
    t.name = n; t.r = r; t.op = op; t.mf = mf; t.cx = cx; t.ex = ex;
    t.st = st; t.ctl = ctl; t.bz = bz; t.sl = sl; t.ab = ab; t.rs = rs; t.dn = dn;
    t.cc = cc;
    vecs.push_back(t);
  endtask

  // Quiet cycle helper: no inputs, idle outputs expected
  task automatic idle(input string n, input int k);
    for (int j = 0; j < k; j++) v(n, 0, NE, 0, 0, 0, 0, NE, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vec_t e;
    logic [8:0] got, want;

    // ---- reset: outputs quiet even with an issuable opcode present
    v("reset",  1, MULT, 1, 0, 1,  0, NE, 0, 0, 0, 0, 0, 1);
    v("reset",  1, MULT, 0, 0, 0,  0, NE, 0, 0, 0, 0, 0, 1);
    idle("post_reset", 1);

    // ---- mult: start at 0, busy 1-4, done at 4, idle at 5
    v("mult_c0", 0, MULT, 0, 0, 0, 1, MULT, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 3; j++) v("mult_busy", 0, NE, 0, 0, 0, 0, NE, 1, 0, 0, 0, 0);
    v("mult_done", 0, NE, 0, 0, 0, 0, NE, 1, 0, 0, 0, 1);
    idle("mult_c5", 1);

    // ---- div with mflo waiting: stall 1-8, done 8, stall clear 9
    v("div_c0", 0, DIV, 0, 0, 0, 1, DIV, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 7; j++) v("div_stall", 0, NE, 1, 0, 0, 0, NE, 1, 1, 0, 0, 0);
    v("div_done", 0, NE, 1, 0, 0, 0, NE, 1, 1, 0, 0, 1);
    v("div_c9", 0, NE, 1, 0, 0, 0, NE, 0, 0, 0, 0, 0);
    idle("gap", 1);

    // ---- multu then divu held in EX: divu starts at 5, busy 6-13
    v("multu_c0", 0, MULTU, 0, 0, 0, 1, MULTU, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 3; j++) v("divu_held", 0, DIVU, 0, 0, 0, 0, NE, 1, 1, 0, 0, 0);
    v("multu_done", 0, DIVU, 0, 0, 0, 0, NE, 1, 1, 0, 0, 1);
    v("divu_start", 0, DIVU, 0, 0, 0, 1, DIVU, 0, 0, 0, 0, 0);
    for (int j = 6; j <= 12; j++) v("divu_busy", 0, NE, 0, 0, 0, 0, NE, 1, 0, 0, 0, 0);
    v("divu_done", 0, NE, 0, 0, 0, 0, NE, 1, 0, 0, 0, 1);
    idle("divu_c14", 1);

    // ---- div aborted by exception on it in MEM: no done ever
    v("abort_c0", 0, DIV, 0, 0, 0, 1, DIV, 0, 0, 0, 0, 0);
    v("abort_c1", 0, NE, 0, 0, 1, 0, NE, 1, 0, 1, 0, 0);
    v("abort_c2", 0, NE, 0, 0, 0, 0, NE, 0, 0, 0, 0, 0, 1);
    idle("abort_nodone", 7);

    // ---- mthi pass-through, then restore on exception
    v("mthi_c0", 0, MTHI, 0, 0, 0, 0, MTHI, 0, 0, 0, 0, 0);
    v("mthi_restore", 0, NE, 0, 0, 1, 0, NE, 0, 0, 0, 1, 0);
    idle("mthi_c2", 1);
    v("mtlo_pass", 0, MTLO, 0, 0, 0, 0, MTLO, 0, 0, 0, 0, 0);
    idle("mtlo_noexc", 1);

    // ---- cancelled opcodes never issue
    v("mult_cancel", 0, MULT, 0, 1, 0, 0, NE, 0, 0, 0, 0, 0);
    v("mtlo_cancel", 0, MTLO, 0, 1, 0, 0, NE, 0, 0, 0, 0, 0);
    v("cancel_after", 0, NE, 0, 0, 1, 0, NE, 0, 0, 0, 0, 0, 1);

    // ---- exceptions not on the MD op; cancelled EX while busy does not stall
    v("exc_mult_c0", 0, MULT, 0, 0, 0, 1, MULT, 0, 0, 0, 0, 0);
    v("exc_cx_c1", 0, DIVU, 0, 1, 0, 0, NE, 1, 0, 0, 0, 0);
    v("exc_late_c2", 0, NE, 0, 0, 1, 0, NE, 1, 0, 0, 0, 0);
    v("exc_late_c3", 0, NE, 0, 0, 1, 0, NE, 1, 0, 0, 0, 0);
    v("exc_expiry", 0, NE, 0, 0, 1, 0, NE, 1, 0, 0, 0, 1);
    idle("exc_c5", 1);

    // ---- reset in the middle of a mult: discarded silently
    v("rst_mult_c0", 0, MULT, 0, 0, 0, 1, MULT, 0, 0, 0, 0, 0);
    v("rst_mult_c1", 0, NE, 0, 0, 0, 0, NE, 1, 0, 0, 0, 0);
    v("rst_mult_c2", 0, NE, 0, 0, 0, 0, NE, 1, 0, 0, 0, 0);
    v("rst_mult_c3", 1, NE, 0, 0, 1, 0, NE, 0, 0, 0, 0, 0);
    v("rst_mult_c4", 0, NE, 0, 0, 1, 0, NE, 0, 0, 0, 0, 0, 1);
    idle("rst_nodone", 3);

    // ---- fresh mult after reset runs full latency again
    v("remult_c0", 0, MULT, 0, 0, 0, 1, MULT, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 3; j++) v("remult_busy", 0, NE, 0, 0, 0, 0, NE, 1, 0, 0, 0, 0);
    v("remult_done", 0, NE, 0, 0, 0, 0, NE, 1, 0, 0, 0, 1);
    idle("remult_c5", 1);

    reset = 1'b1; md_op_ex = NE; mf_ex = 1'b0; cancel_ex = 1'b0; exc_mem = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset     = vecs[i].r;
      md_op_ex  = vecs[i].op;
      mf_ex     = vecs[i].mf;
      cancel_ex = vecs[i].cx;
      exc_mem   = vecs[i].ex;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at vec %0d", i);
      end else begin
        e    = exp_q.pop_front();
        got  = {start, md_ctrl, busy, stall, abort, restore, done};
        want = {e.st, e.ctl, e.bz, e.sl, e.ab, e.rs, e.dn};
        if (got !== want) begin
          errors++;
          $display("FAIL %s (vec %0d): got st/ctl/bz/sl/ab/rs/dn=%b want %b", e.name, i, got, want);
        end
        if (e.cc) begin
          checks++;
          if (dut.u_cnt.cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL %s_cnt (vec %0d): got counter=%0d want 0", e.name, i, dut.u_cnt.cnt_q);
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
